line_pixel_fetch: RTL and testbench
===================================

Name: line_pixel_fetch

Overview:
- Downstream consumer of the 64x32-write / 128x16-read SDPB line buffer in the HDMI graphics path, running on the pixel clock.
- Walks the read-port address (adb[6:0]) in step with video timing and repeats each buffered pixel SCALE_X times.
- Expands RGB565 words to RGB888 and re-aligns hsync/vsync/de to the 2-cycle read+output pipeline.
- Runs a per-line refill handshake with the MCU writer and flags underruns.

Parameters:
- SCALE_X, 4, output pixels per buffered pixel (power of two, 1..8)
- SRC_W, 128, buffered pixels per line (1..128; read address wraps at SRC_W-1)
- WIN_X0, 32, first active column (counted from de rise) that shows buffer data
- BORDER_RGB, 24'h000000, colour outside window, or for the whole line on underrun

Ports:
- clk  in  1  pixel clock; also drives SDPB clkb
- rst_n  in  1  asynchronous active-low reset
- vid_de  in  1  active-video from timing generator
- vid_hs  in  1  hsync from timing generator
- vid_vs  in  1  vsync from timing generator
- buf_adb  out  7  SDPB read address
- buf_ceb  out  1  SDPB read clock enable
- buf_oce  out  1  SDPB output clock enable (tied equal to buf_ceb)
- buf_dout  in  16  SDPB read data, RGB565, valid 1 cycle after address
- fill_req  out  1  request MCU refill of the line buffer
- fill_line  out  11  source line index to load
- fill_ack  in  1  MCU has finished writing the requested line
- out_rgb  out  24  RGB888 pixel
- out_de  out  1  vid_de delayed 2 cycles
- out_hs  out  1  vid_hs delayed 2 cycles
- out_vs  out  1  vid_vs delayed 2 cycles
- underrun  out  1  sticky; set when a line starts with fill_req still pending

Behaviour:
- Reset (async, rst_n low): all outputs 0, including out_rgb, buf_adb, fill_req, fill_line and underrun. State = IDLE. Counters = 0. line_ok = 1.
- Latency: out_* = inputs delayed exactly 2 clk. Stage 1 issues the address; stage 2 registers the expanded dout.
- Column counter col: cleared at de rise, increments while vid_de=1.
- Window active when WIN_X0 <= col < WIN_X0 + SRC_W*SCALE_X.
- In window: buf_ceb=1. Sub-counter rep counts 0..SCALE_X-1; buf_adb increments when rep wraps. buf_adb is 0 at window entry and wraps SRC_W-1 -> 0.
- Outside window: buf_ceb=0, buf_adb held.
- States:
  - IDLE: vid_de=0. vid_de rise -> ACTIVE.
  - ACTIVE: vid_de=1. vid_de fall -> REFILL.
  - REFILL: fill_req=1 and fill_line=line+1; fill_ack -> IDLE with fill_req=0 and line_ok=1.
- Line counter line (11 bit): increments at each de fall; cleared on vid_vs rising edge.
- At vsync rise, fill_line is set to 0 and a request is raised if not already pending. A pending request keeps waiting.
- Underrun: vid_de rises while fill_req=1 -> underrun<=1 (sticky until reset) and line_ok=0. That whole line outputs BORDER_RGB. The FSM stays in REFILL, tracking de only for counters.
- fill_ack while fill_req=0 is ignored. fill_ack and de rise in the same cycle: ack wins, no underrun.
- Expansion: R8={r5,r5[4:2]}, G8={g6,g6[5:4]}, B8={b5,b5[4:2]}.
- Pixels outside the window, or with out_de=0, output BORDER_RGB when de=1 and 0 when de=0.

Optional Feature:
- LINE_FETCH_TESTPAT_EN defined: adds input test_mode (1 bit). When test_mode=1, buffer reads are suppressed (buf_ceb=0). out_rgb shows 8 vertical colour bars: bar index = col[9:7], colour = {8{idx[2]},8{idx[1]},8{idx[0]}}. The fill handshake still runs.
- Macro undefined: no test_mode port and no bar logic.

Decomposition:
- Package hdmi_fetch_pkg holds:
  - RGB565 field slice constants
  - the FSM state enum (IDLE/ACTIVE/REFILL)
  - line width constant (11)
- One sub-module, rgb565_to_rgb888 (combinational expander), instantiated in stage 2.

Test Plan:
- Reset release, de held low -> all outputs 0, fill_req=0, underrun=0.
- SCALE_X=4, WIN_X0=32, buffer model returning dout=adb -> buf_adb=0 during cols 32-35 and 1 during cols 36-39. out_rgb for word 16'hF800 = 24'hFF0000, 2 cycles after that column's vid_de.
- Buffer addresses across 512 window columns -> buf_adb wraps 127->0 exactly once, at window end. Column 544 onward outputs BORDER_RGB.
- de falls on line 5 -> fill_req=1 with fill_line=6; fill_ack 10 cycles later -> fill_req=0 next cycle; next line renders buffer data.
- Withhold fill_ack past the next de rise -> underrun=1 (stays set), that line is all BORDER_RGB; a later ack clears fill_req and the following line renders normally.
- vsync pulse mid-frame -> line=0, fill_line=0 request raised; out_vs equals vid_vs delayed exactly 2 cycles.

Source files
------------

// File: rtl/hdmi_fetch_pkg.sv
// hdmi_fetch_pkg: shared constants and types for the line-buffer pixel fetch path
package hdmi_fetch_pkg;
  localparam int LINE_W = 11;
  localparam int R_HI = 15;
  localparam int R_LO = 11;
  localparam int G_HI = 10;
  localparam int G_LO = 5;
  localparam int B_HI = 4;
  localparam int B_LO = 0;
  typedef enum logic [1:0] {IDLE, ACTIVE, REFILL} state_t;
endpackage

// File: rtl/line_pixel_fetch_rgb565_to_rgb888.sv
// rgb565_to_rgb888: widens RGB565 to RGB888 by replicating each field's top bits
module rgb565_to_rgb888
  import hdmi_fetch_pkg::*;
(
  input  logic [15:0] rgb565,
  output logic [23:0] rgb888
);
  assign rgb888 = {rgb565[R_HI:R_LO], rgb565[R_HI -: 3],
                   rgb565[G_HI:G_LO], rgb565[G_HI -: 2],
                   rgb565[B_HI:B_LO], rgb565[B_HI -: 3]};
endmodule

// File: rtl/line_pixel_fetch.sv
// line_pixel_fetch: walks the SDPB read port in step with video timing, scales and expands pixels.
// Defining LINE_FETCH_TESTPAT_EN adds a test_mode input that replaces buffer data with colour bars.
module line_pixel_fetch
  import hdmi_fetch_pkg::*;
#(
  parameter int          SCALE_X    = 4,
  parameter int          SRC_W      = 128,
  parameter int          WIN_X0     = 32,
  parameter logic [23:0] BORDER_RGB = 24'h000000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              vid_de,
  input  logic              vid_hs,
  input  logic              vid_vs,
  output logic [6:0]        buf_adb,
  output logic              buf_ceb,
  output logic              buf_oce,
  input  logic [15:0]       buf_dout,
  output logic              fill_req,
  output logic [LINE_W-1:0] fill_line,
  input  logic              fill_ack,
  output logic [23:0]       out_rgb,
  output logic              out_de,
  output logic              out_hs,
  output logic              out_vs,
  output logic              underrun
`ifdef LINE_FETCH_TESTPAT_EN
  ,
  input  logic              test_mode
`endif
);
  localparam logic [11:0] X0 = 12'(WIN_X0);
  localparam logic [11:0] X1 = 12'(WIN_X0 + SRC_W * SCALE_X);
  localparam logic [2:0] REP_MAX = 3'(SCALE_X - 1);
  localparam logic [6:0] ADB_MAX = 7'(SRC_W - 1);
  state_t state;
  logic [LINE_W-1:0] line;
  logic [11:0] col;
  logic [2:0] rep;
  logic de_q, vs_q, line_ok, show1, de1, hs1, vs1;
  logic de_rise, de_fall, vs_rise, ack, win, ok_now;
  logic [23:0] rgb888;
  assign de_rise = vid_de & ~de_q;
  assign de_fall = ~vid_de & de_q;
  assign vs_rise = vid_vs & ~vs_q;
  assign ack = fill_ack & fill_req;
  assign win = vid_de && col >= X0 && col < X1;
  // an ack landing on the same cycle as de rise still counts as a filled line
  assign ok_now = de_rise ? ~(fill_req & ~fill_ack) : line_ok;
`ifdef LINE_FETCH_TESTPAT_EN
  logic tm1;
  logic [2:0] bar1;
  assign buf_ceb = win & ~test_mode;
`else
  assign buf_ceb = win;
`endif
  assign buf_oce = buf_ceb;

  rgb565_to_rgb888 u_exp (.rgb565(buf_dout), .rgb888(rgb888));

  // col and the read address restart from 0 whenever de is low
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col <= '0;
      rep <= '0;
      buf_adb <= '0;
      de_q <= 1'b0;
      vs_q <= 1'b0;
    end else begin
      de_q <= vid_de;
      vs_q <= vid_vs;
      col <= !vid_de ? '0 : (&col) ? col : col + 12'd1;
      if (!vid_de) begin
        rep <= '0;
        buf_adb <= '0;
      end else if (win) begin
        rep <= rep == REP_MAX ? '0 : rep + 3'd1;
        if (rep == REP_MAX) buf_adb <= buf_adb == ADB_MAX ? '0 : buf_adb + 7'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      {de1, hs1, vs1, show1} <= '0;
      {out_de, out_hs, out_vs} <= '0;
      out_rgb <= '0;
`ifdef LINE_FETCH_TESTPAT_EN
      tm1 <= 1'b0;
      bar1 <= '0;
`endif
    end else begin
      {de1, hs1, vs1} <= {vid_de, vid_hs, vid_vs};
      show1 <= win & ok_now;
      {out_de, out_hs, out_vs} <= {de1, hs1, vs1};
`ifdef LINE_FETCH_TESTPAT_EN
      tm1 <= test_mode;
      bar1 <= col[9:7];
      out_rgb <= !de1 ? '0 : tm1 ? {{8{bar1[2]}}, {8{bar1[1]}}, {8{bar1[0]}}} :
                 show1 ? rgb888 : BORDER_RGB;
`else
      out_rgb <= !de1 ? '0 : show1 ? rgb888 : BORDER_RGB;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      line <= '0;
      fill_req <= 1'b0;
      fill_line <= '0;
      underrun <= 1'b0;
      line_ok <= 1'b1;
    end else begin
      if (ack) fill_req <= 1'b0;
      if (de_rise) begin
        line_ok <= ok_now;
        if (!ok_now) underrun <= 1'b1;
        state <= ok_now ? ACTIVE : REFILL;
      end else if (de_fall && state == ACTIVE) begin
        state <= REFILL;
        fill_req <= 1'b1;
        fill_line <= line + LINE_W'(1);
      end else if (ack && state == REFILL) begin
        state <= IDLE;
      end
      if (de_fall) line <= line + LINE_W'(1);
      // frame start always asks for line 0; re-raising a pending request is a no-op
      if (vs_rise) begin
        line <= '0;
        fill_line <= '0;
        fill_req <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_line_pixel_fetch.sv
// tb_line_pixel_fetch: directed bench for line_pixel_fetch with a synchronous buffer model
module tb_line_pixel_fetch;
  localparam logic [23:0] BORDER = 24'h123456;
  localparam int N = 600;
  logic clk = 0, rst_n = 0, vid_de = 0, vid_hs = 0, vid_vs = 0, fill_ack = 0;
  logic [15:0] buf_dout = '0;
  logic [6:0] buf_adb, adb_now;
  logic buf_ceb, buf_oce, fill_req, out_de, out_hs, out_vs, underrun, ceb_now, oce_now;
  logic [10:0] fill_line;
  logic [23:0] out_rgb;
  int tests = 0, failed = 0;

  always #5 clk = ~clk;

  line_pixel_fetch #(.BORDER_RGB(BORDER)) dut (
    .clk(clk), .rst_n(rst_n), .vid_de(vid_de), .vid_hs(vid_hs), .vid_vs(vid_vs),
    .buf_adb(buf_adb), .buf_ceb(buf_ceb), .buf_oce(buf_oce), .buf_dout(buf_dout),
    .fill_req(fill_req), .fill_line(fill_line), .fill_ack(fill_ack),
    .out_rgb(out_rgb), .out_de(out_de), .out_hs(out_hs), .out_vs(out_vs), .underrun(underrun)
  );

  function automatic logic [15:0] mem_word(input logic [6:0] a);
    return a == 7'd0 ? 16'hF800 : a == 7'd1 ? 16'h07E0 : a == 7'd2 ? 16'h001F : {9'b0, a};
  endfunction

  always @(posedge clk) buf_dout <= mem_word(buf_adb);

  function automatic bit inwin(input int c);
    return c >= 32 && c < 544;
  endfunction

  function automatic logic [6:0] exp_adb(input int c);
    return inwin(c) ? 7'(((c - 32) / 4) % 128) : 7'd0;
  endfunction

  function automatic logic [23:0] exp_pix(input int c, input bit ok);
    if (!ok || !inwin(c)) return BORDER;
    case (exp_adb(c))
      7'd0:    return 24'hFF0000;
      7'd1:    return 24'h00FF00;
      7'd2:    return 24'h0000FF;
      7'd67:   return 24'h000818;
      7'd127:  return 24'h000CFF;
      default: return 24'hxxxxxx;
    endcase
  endfunction

  function automatic bit is_chk(input int c);
    return c inside {0, 31, 32, 35, 36, 39, 40, 300, 540, 543, 544, 599};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic de, input logic hs, input logic vs, input logic ack);
    vid_de = de;
    vid_hs = hs;
    vid_vs = vs;
    fill_ack = ack;
    #1;
    adb_now = buf_adb;
    ceb_now = buf_ceb;
    oce_now = buf_oce;
    @(posedge clk);
    #2;
    fill_ack = 0;
  endtask

  task automatic run_line(input bit ok, input bit ack_rise, input logic exp_under);
    for (int c = 0; c <= N; c++) begin
      step(c < N, 0, 0, ack_rise && c == 0);
      if (c < N && is_chk(c)) begin
        chk("buf_adb", adb_now, exp_adb(c));
        chk("buf_ceb", ceb_now, inwin(c));
        chk("buf_oce", oce_now, inwin(c));
      end
      if (c == 0) begin
        chk("out_de_latency", out_de, 0);
        chk("underrun", underrun, exp_under);
      end
      if (c >= 1 && is_chk(c - 1)) begin
        chk("out_de", out_de, 1);
        chk("out_rgb", out_rgb, exp_pix(c - 1, ok));
      end
    end
  endtask

  task automatic ack_after(input int n);
    repeat (n) step(0, 0, 0, 0);
    step(0, 0, 0, 1);
    chk("fill_req_after_ack", fill_req, 0);
  endtask

  initial begin
    logic ph, pv, hs, vs;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_out_rgb", out_rgb, 0);
    chk("rst_buf_adb", buf_adb, 0);
    chk("rst_buf_ceb", buf_ceb, 0);
    chk("rst_fill_req", fill_req, 0);
    chk("rst_fill_line", fill_line, 0);
    chk("rst_underrun", underrun, 0);
    chk("rst_out_sync", {out_de, out_hs, out_vs}, 0);
    rst_n = 1;
    repeat (3) step(0, 0, 0, 0);
    chk("idle_fill_req", fill_req, 0);
    chk("idle_out_rgb", out_rgb, 0);
    chk("idle_underrun", underrun, 0);
    // lines 0..5; line 1's request is acked on the very cycle line 2's de rises
    for (int ln = 0; ln < 6; ln++) begin
      run_line(1, ln == 2, 0);
      chk("fill_req_line_end", fill_req, 1);
      chk("fill_line", fill_line, 32'(ln + 1));
      if (ln == 1) begin
        repeat (5) step(0, 0, 0, 0);
        chk("fill_req_waiting", fill_req, 1);
      end else ack_after(10);
    end
    run_line(1, 0, 0);
    chk("fill_line_7", fill_line, 7);
    repeat (5) step(0, 0, 0, 0);
    run_line(0, 0, 1);
    chk("fill_req_pending", fill_req, 1);
    chk("fill_line_held", fill_line, 7);
    ack_after(3);
    chk("underrun_sticky", underrun, 1);
    run_line(1, 0, 1);
    chk("fill_line_9", fill_line, 9);
    ack_after(4);
    ph = 0;
    pv = 0;
    for (int i = 0; i < 10; i++) begin
      hs = i inside {1, 2};
      vs = i inside {3, 4, 5};
      step(0, hs, vs, 0);
      chk("out_hs_delay", out_hs, ph);
      chk("out_vs_delay", out_vs, pv);
      if (i == 3) begin
        chk("vs_fill_req", fill_req, 1);
        chk("vs_fill_line", fill_line, 0);
      end
      ph = hs;
      pv = vs;
    end
    ack_after(2);
    run_line(1, 0, 1);
    chk("fill_line_after_vs", fill_line, 1);
    ack_after(2);
    chk("underrun_final", underrun, 1);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
